// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset / lock-supervision sequencer.
package pll_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  localparam int RETRY_W  = 4;
  localparam int UNLOCK_W = 8;

  // Width of the cycle counters: wide enough for the largest programmed period.
  function automatic int cnt_width(input int rst_pulse,
                                   input int lock_stable,
                                   input int lock_timeout);
    int max_v;
    max_v = rst_pulse;
    if (lock_stable > max_v) begin
      max_v = lock_stable;
    end else begin
      max_v = max_v;
    end
    if (lock_timeout > max_v) begin
      max_v = lock_timeout;
    end else begin
      max_v = max_v;
    end
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      q_r    <= RST_VAL;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset and lock-supervision sequencer: pulses the PLL reset, waits for a
// stable lock, releases the downstream reset, and retries on timeout or loss.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 7
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                ready,
  output logic                fail,
  output logic [RETRY_W-1:0]  retry_cnt,
  output logic [UNLOCK_W-1:0] unlock_cnt
);

  localparam int CW = cnt_width(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT);

  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] STB_LAST    = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]    RETRY_LIMIT = 5'(MAX_RETRY);

  seq_state_e          state_r;
  seq_state_e          state_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_s;
  logic [CW-1:0]       stab_r;
  logic [CW-1:0]       stab_s;
  logic [RETRY_W-1:0]  retry_r;
  logic [RETRY_W-1:0]  retry_s;
  logic [UNLOCK_W-1:0] unlock_r;
  logic [UNLOCK_W-1:0] unlock_s;
  logic [4:0]          retry_inc_s;
  logic [RETRY_W-1:0]  retry_sat_s;
  logic                retry_over_s;
  logic                lk_s;

  logic pll_rst_r;
  logic sys_rst_r;
  logic ready_r;
  logic fail_r;
  logic pll_rst_s;
  logic sys_rst_s;
  logic ready_s;
  logic fail_s;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // Retry arithmetic on a failed attempt: one bit wider so the limit compare
  // cannot wrap, and the visible count saturates at its 4-bit ceiling.
  always_comb begin
    retry_inc_s  = {1'b0, retry_r} + 5'd1;
    retry_over_s = (retry_inc_s > RETRY_LIMIT);
    if (retry_inc_s[4]) begin
      retry_sat_s = 4'hF;
    end else begin
      retry_sat_s = retry_inc_s[3:0];
    end
  end

  // Next-state and counter update; req overrides every other transition.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    stab_s   = stab_r;
    retry_s  = retry_r;
    unlock_s = unlock_r;
    if (req) begin
      state_s  = ST_RESET;
      cnt_s    = CNT_ZERO;
      stab_s   = CNT_ZERO;
      retry_s  = 4'd0;
      unlock_s = 8'd0;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (cnt_r == RST_LAST) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // A timeout wins over a same-cycle lock so an attempt cannot outlive its budget.
          if (cnt_r == TMO_LAST) begin
            retry_s = retry_sat_s;
            cnt_s   = CNT_ZERO;
            stab_s  = CNT_ZERO;
            if (retry_over_s) begin
              state_s = ST_FAIL;
            end else begin
              state_s = ST_RESET;
            end
          end else if (lk_s) begin
            state_s = ST_STABLE;
            stab_s  = CNT_ZERO;
            cnt_s   = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          // Stability completion beats a coincident timeout.
          if (lk_s && (stab_r == STB_LAST)) begin
            state_s = ST_RUN;
            cnt_s   = CNT_ZERO;
            stab_s  = CNT_ZERO;
          end else if (cnt_r == TMO_LAST) begin
            retry_s = retry_sat_s;
            cnt_s   = CNT_ZERO;
            stab_s  = CNT_ZERO;
            if (retry_over_s) begin
              state_s = ST_FAIL;
            end else begin
              state_s = ST_RESET;
            end
          end else if (!lk_s) begin
            // Lock dropped: go back to waiting but keep the attempt's timeout count.
            state_s = ST_WAIT_LOCK;
            stab_s  = CNT_ZERO;
            cnt_s   = cnt_r + CNT_ONE;
          end else begin
            stab_s = stab_r + CNT_ONE;
            cnt_s  = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_s = ST_RESET;
            cnt_s   = CNT_ZERO;
            stab_s  = CNT_ZERO;
            if (unlock_r != 8'hFF) begin
              unlock_s = unlock_r + 8'd1;
            end else begin
              unlock_s = unlock_r;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_s = ST_FAIL;
        end
        default: begin
          state_s = ST_RESET;
          cnt_s   = CNT_ZERO;
          stab_s  = CNT_ZERO;
        end
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track it with no lag.
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    ready_s   = 1'b0;
    fail_s    = 1'b0;
    case (state_s)
      ST_RESET: begin
        pll_rst_s = 1'b1;
      end
      ST_WAIT_LOCK: begin
        pll_rst_s = 1'b0;
      end
      ST_STABLE: begin
        pll_rst_s = 1'b0;
      end
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        ready_s   = 1'b1;
      end
      ST_FAIL: begin
        fail_s = 1'b1;
      end
      default: begin
        pll_rst_s = 1'b1;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RESET;
      cnt_r     <= CNT_ZERO;
      stab_r    <= CNT_ZERO;
      retry_r   <= 4'd0;
      unlock_r  <= 8'd0;
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      stab_r    <= stab_s;
      retry_r   <= retry_s;
      unlock_r  <= unlock_s;
      pll_rst_r <= pll_rst_s;
      sys_rst_r <= sys_rst_s;
      ready_r   <= ready_s;
      fail_r    <= fail_s;
    end
  end

  assign pll_rst    = pll_rst_r;
  assign sys_rst    = sys_rst_r;
  assign ready      = ready_r;
  assign fail       = fail_r;
  assign retry_cnt  = retry_r;
  assign unlock_cnt = unlock_r;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq with
// RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
// Latencies are counted in rising edges after an input change made 1 time
// unit after an edge: a lock rise needs 2 synchronizer edges, 1 edge for
// WAIT_LOCK to see it, then 8 edges in STABLE (11 total); with lock already
// synchronized at WAIT_LOCK entry the release comes 1 + 8 = 9 edges later.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst_n;
  logic       req;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] unlock_cnt;

  int n_checks;
  int n_fail;

  pll_reset_seq #(
    .RST_PULSE    (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .MAX_RETRY    (2)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .req        (req),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .unlock_cnt (unlock_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Edges until pll_rst is seen low (bounded).
  task automatic count_pll_rst(output int n);
    n = 0;
    do begin step(); n++; end while (pll_rst !== 1'b0 && n < 200);
  endtask

  // Edges until sys_rst is seen at the given level (bounded).
  task automatic count_sys_rst(input logic lvl, output int n);
    n = 0;
    do begin step(); n++; end while (sys_rst !== lvl && n < 200);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; req = 1'b0; pll_locked = 1'b0;
    repeat (3) step();
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b expected 1", pll_rst); end
    n_checks++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b expected 0", fail); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retry: got %0d expected 0", retry_cnt); end
    n_checks++; if (unlock_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_unlock: got %0d expected 0", unlock_cnt); end
    rst_n = 1'b1;
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL first_pll_rst_len: got %0d expected 4", n); end
  endtask

  task automatic test_first_lock();
    int n;
    repeat (5) step();
    n_checks++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL wait_sys_rst: got %b expected 1", sys_rst); end
    pll_locked = 1'b1;
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 11) begin n_fail++; $display("FAIL lock_to_release: got %0d expected 11", n); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b expected 1", ready); end
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL run_pll_rst: got %b expected 0", pll_rst); end
  endtask

  task automatic test_unlock();
    int n;
    pll_locked = 1'b0;
    count_sys_rst(1'b1, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL unlock_latency: got %0d expected 3", n); end
    n_checks++; if (unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL unlock_cnt: got %0d expected 1", unlock_cnt); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL unlock_retry: got %0d expected 0", retry_cnt); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL unlock_ready: got %b expected 0", ready); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL unlock_pll_rst: got %b expected 1", pll_rst); end
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL repulse_len: got %0d expected 4", n); end
    pll_locked = 1'b1;
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 11) begin n_fail++; $display("FAIL relock_release: got %0d expected 11", n); end
    n_checks++; if (unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL unlock_cnt_hold: got %0d expected 1", unlock_cnt); end
  endtask

  task automatic test_timeout_fail();
    int n;
    int bad;
    logic [3:0] prev;
    pll_locked = 1'b0;
    req = 1'b1; step(); req = 1'b0;
    n_checks++; if (unlock_cnt !== 8'd0) begin n_fail++; $display("FAIL req_clears_unlock: got %0d expected 0", unlock_cnt); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL req_pll_rst: got %b expected 1", pll_rst); end
    for (int k = 1; k <= 3; k++) begin
      prev = retry_cnt;
      n = 0;
      do begin step(); n++; end while (retry_cnt === prev && n < 200);
      n_checks++; if (n !== 36) begin n_fail++; $display("FAIL attempt_len_%0d: got %0d expected 36", k, n); end
      n_checks++; if (retry_cnt !== 4'(k)) begin n_fail++; $display("FAIL retry_step_%0d: got %0d expected %0d", k, retry_cnt, k); end
      n_checks++; if (fail !== (k == 3)) begin n_fail++; $display("FAIL fail_flag_%0d: got %b expected %b", k, fail, (k == 3)); end
      n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_pll_rst_%0d: got %b expected 1", k, pll_rst); end
    end
    bad = 0;
    repeat (40) begin
      step();
      if (fail !== 1'b1 || retry_cnt !== 4'd3 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL fail_parked: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_req_from_fail();
    int n;
    pll_locked = 1'b1;
    repeat (3) step();
    n_checks++; if (fail !== 1'b1) begin n_fail++; $display("FAIL fail_ignores_lock: got %b expected 1", fail); end
    req = 1'b1; step(); req = 1'b0;
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL req_clears_retry: got %0d expected 0", retry_cnt); end
    n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL req_leaves_fail: got %b expected 0", fail); end
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL req_pulse_len: got %0d expected 4", n); end
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL req_release: got %0d expected 9", n); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL req_ready: got %b expected 1", ready); end
  endtask

  task automatic test_stable_glitch();
    int n;
    pll_locked = 1'b0;
    req = 1'b1; step(); req = 1'b0;
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL glitch_pulse_len: got %0d expected 4", n); end
    pll_locked = 1'b1;
    repeat (8) step();
    n_checks++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL glitch_pre_sys_rst: got %b expected 1", sys_rst); end
    pll_locked = 1'b0;
    repeat (2) step();
    pll_locked = 1'b1;
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 11) begin n_fail++; $display("FAIL glitch_release: got %0d expected 11", n); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL glitch_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_async_reset();
    int n;
    // Abort in WAIT_LOCK after one timeout.
    pll_locked = 1'b0;
    req = 1'b1; step(); req = 1'b0;
    repeat (46) step();
    n_checks++; if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL pre_abort_retry: got %0d expected 1", retry_cnt); end
    n_checks++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL pre_abort_wait: got %b expected 0", pll_rst); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL wait_abort_pll_rst: got %b expected 1", pll_rst); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL wait_abort_retry: got %0d expected 0", retry_cnt); end
    repeat (2) step();
    rst_n = 1'b1;
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL wait_abort_pulse: got %0d expected 4", n); end
    pll_locked = 1'b1;
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 11) begin n_fail++; $display("FAIL wait_abort_release: got %0d expected 11", n); end
    // Collect one unlock, then abort in RUN.
    pll_locked = 1'b0;
    count_sys_rst(1'b1, n);
    count_pll_rst(n);
    pll_locked = 1'b1;
    count_sys_rst(1'b0, n);
    n_checks++; if (unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL pre_abort_unlock: got %0d expected 1", unlock_cnt); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL run_abort_ready: got %b expected 0", ready); end
    n_checks++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL run_abort_sys_rst: got %b expected 1", sys_rst); end
    n_checks++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL run_abort_pll_rst: got %b expected 1", pll_rst); end
    n_checks++; if (unlock_cnt !== 8'd0) begin n_fail++; $display("FAIL run_abort_unlock: got %0d expected 0", unlock_cnt); end
    repeat (2) step();
    rst_n = 1'b1;
    count_pll_rst(n);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL run_abort_pulse: got %0d expected 4", n); end
    count_sys_rst(1'b0, n);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL run_abort_release: got %0d expected 9", n); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL run_abort_ready_again: got %b expected 1", ready); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_lock();
    test_unlock();
    test_timeout_fail();
    test_req_from_fail();
    test_stable_glitch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
